ov7670_config_sequencer: RTL and testbench

OV7670_CONFIG_SEQUENCER -- requirements
Module: ov7670_config_sequencer

---
 rtl/ov7670_config_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer.sv
// Walks a combinational register LUT and writes each entry to the camera over an SCCB write master,
// with power-up and inter-write delays, NACK retries and a held done/error result.
module ov7670_config_sequencer #(
  parameter logic [7:0]  START_INDEX    = 8'd2,
  parameter logic [7:0]  END_INDEX      = 8'd167,
  parameter logic [7:0]  DEV_ADDR       = 8'h42,
  parameter logic [23:0] POWERUP_CYCLES = 24'd1_250_000,
  parameter logic [15:0] GAP_CYCLES     = 16'd2_500,
  parameter logic [7:0]  MAX_RETRY      = 8'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  lut_index,
  input  logic [15:0] lut_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_dev,
  output logic [7:0]  wr_reg,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        wr_nack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [7:0]  fail_index
);

  // Counters are loaded with N-1 so a phase lasts exactly N cycles; zero lengths collapse to one cycle.
  localparam logic [23:0] PU_LOAD  = (POWERUP_CYCLES == 24'd0) ? 24'd0 : POWERUP_CYCLES - 24'd1;
  localparam logic [23:0] GAP_LOAD = (GAP_CYCLES == 16'd0) ? 24'd0 : {8'd0, GAP_CYCLES - 16'd1};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POWERUP = 3'd1,
    S_FETCH   = 3'd2,
    S_ISSUE   = 3'd3,
    S_WAIT    = 3'd4,
    S_GAP     = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [23:0] cnt_r;
  logic [7:0]  lut_index_r;
  logic [7:0]  retry_r;
  logic        regap_r;
  logic        soft_r;
  logic [7:0]  wr_reg_r;
  logic [7:0]  wr_data_r;
  logic        wr_valid_r;
  logic        busy_r;
  logic        cfg_done_r;
  logic        cfg_error_r;
  logic [7:0]  fail_index_r;

  logic        accept_s;
  logic        ack_s;
  logic        nack_s;
  logic        busy_s;
  logic        enter_pu_s;
  logic        enter_gap_s;

  // Next-state decode and transaction strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    ack_s    = 1'b0;
    nack_s   = 1'b0;
    case (state_r)
      S_IDLE: state_s = S_POWERUP;
      S_POWERUP: begin
        if (cnt_r == 24'd0) state_s = S_FETCH;
        else                state_s = S_POWERUP;
      end
      S_FETCH: state_s = S_ISSUE;
      S_ISSUE: begin
        if (wr_ready) begin
          accept_s = 1'b1;
          state_s  = S_WAIT;
        end else begin
          state_s  = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (wr_done && !wr_nack) begin
          ack_s = 1'b1;
          if (lut_index_r == END_INDEX) state_s = S_DONE;
          else                          state_s = S_GAP;
        end else if (wr_done) begin
          nack_s = 1'b1;
          if (retry_r < MAX_RETRY) state_s = S_GAP;
          else                     state_s = S_ERROR;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_GAP: begin
        if (cnt_r != 24'd0) state_s = S_GAP;
        else if (regap_r)   state_s = S_ISSUE;
        else                state_s = S_FETCH;
      end
      S_DONE, S_ERROR: begin
        if (start) state_s = S_POWERUP;
        else       state_s = state_r;
      end
      default: state_s = S_IDLE;
    endcase
  end

  assign busy_s      = (state_s == S_POWERUP) || (state_s == S_FETCH) || (state_s == S_ISSUE) ||
                       (state_s == S_WAIT) || (state_s == S_GAP);
  assign enter_pu_s  = (state_s == S_POWERUP) && (state_r != S_POWERUP);
  assign enter_gap_s = (state_s == S_GAP) && (state_r != S_GAP);

  // State register and status outputs, registered from the next state so they track it exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      wr_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      cfg_done_r  <= 1'b0;
      cfg_error_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      wr_valid_r  <= (state_s == S_ISSUE);
      busy_r      <= busy_s;
      cfg_done_r  <= (state_s == S_DONE);
      cfg_error_r <= (state_s == S_ERROR);
    end
  end

  // Delay counter, LUT walk, retry bookkeeping and the write payload
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= 24'd0;
      lut_index_r  <= START_INDEX;
      retry_r      <= 8'd0;
      regap_r      <= 1'b0;
      soft_r       <= 1'b0;
      wr_reg_r     <= 8'd0;
      wr_data_r    <= 8'd0;
      fail_index_r <= 8'd0;
    end else begin
      // A COM7 reset puts the camera back through power-up, so its gap waits the power-up time
      if (enter_pu_s)            cnt_r <= PU_LOAD;
      else if (enter_gap_s)      cnt_r <= soft_r ? PU_LOAD : GAP_LOAD;
      else if (cnt_r != 24'd0)   cnt_r <= cnt_r - 24'd1;

      if (enter_pu_s) begin
        lut_index_r <= START_INDEX;
        retry_r     <= 8'd0;
        regap_r     <= 1'b0;
      end else if (ack_s) begin
        if (lut_index_r != END_INDEX) lut_index_r <= lut_index_r + 8'd1;
        retry_r <= 8'd0;
        regap_r <= 1'b0;
      end else if (nack_s && (retry_r < MAX_RETRY)) begin
        retry_r <= retry_r + 8'd1;
        regap_r <= 1'b1;
      end

      if (enter_pu_s)                           fail_index_r <= 8'd0;
      else if (nack_s && (retry_r >= MAX_RETRY)) fail_index_r <= lut_index_r;

      if (state_r == S_FETCH) begin
        wr_reg_r  <= lut_data[15:8];
        wr_data_r <= lut_data[7:0];
      end

      if (accept_s) soft_r <= (wr_reg_r == 8'h12) && wr_data_r[7];
    end
  end

  assign lut_index  = lut_index_r;
  assign wr_valid   = wr_valid_r;
  assign wr_dev     = DEV_ADDR;
  assign wr_reg     = wr_reg_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;
  assign cfg_done   = cfg_done_r;
  assign cfg_error  = cfg_error_r;
  assign fail_index = fail_index_r;

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: random LUT, an SCCB master responder, and a timing model of the
// expected write stream built from phase durations.
`timescale 1ns/1ps
module tb_ov7670_config_sequencer;

  localparam int P    = 10;
  localparam int G    = 4;
  localparam int MAXR = 3;
  localparam int SIDX = 2;
  localparam int EIDX = 167;

  typedef struct {
    logic [7:0] rg;
    logic [7:0] dt;
    int         idx;
    int         cyc;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  lut_index, wr_dev, wr_reg, wr_data, fail_index;
  logic [15:0] lut_data;
  logic        wr_valid, wr_ready, wr_done, wr_nack, busy, cfg_done, cfg_error;

  logic        start1 = 1'b0;
  logic [7:0]  lut_index1, wr_dev1, wr_reg1, wr_data1, fail_index1;
  logic [15:0] lut_data1;
  logic        wr_valid1, wr_ready1, wr_done1, wr_nack1, busy1, cfg_done1, cfg_error1;

  logic [15:0] lut_mem [256];
  acc_t        acc_q[$];
  acc_t        exp_q[$];
  acc_t        acc1_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          nack_idx = 255, nack_n = 0, bp_idx = 255, bp_len = 0;

  assign lut_data  = lut_mem[lut_index];
  assign lut_data1 = lut_mem[lut_index1];

  ov7670_config_sequencer #(
    .POWERUP_CYCLES(24'd10), .GAP_CYCLES(16'd4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lut_index(lut_index), .lut_data(lut_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_done(wr_done), .wr_nack(wr_nack), .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .fail_index(fail_index)
  );

  ov7670_config_sequencer #(
    .START_INDEX(8'd9), .END_INDEX(8'd9), .DEV_ADDR(8'h21),
    .POWERUP_CYCLES(24'd3), .GAP_CYCLES(16'd0), .MAX_RETRY(8'd3)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .lut_index(lut_index1), .lut_data(lut_data1),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_dev(wr_dev1), .wr_reg(wr_reg1), .wr_data(wr_data1),
    .wr_done(wr_done1), .wr_nack(wr_nack1), .busy(busy1), .cfg_done(cfg_done1), .cfg_error(cfg_error1),
    .fail_index(fail_index1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SCCB master: records accepts at the negedge, drives ready/done just after the posedge
  initial begin
    acc_t a;
    int done_cnt = 0, done1_cnt = 0, attempts = 0, last_idx = 255, stall_cnt = 0;
    bit pend_nack = 1'b0, pend_nack1 = 1'b0;
    wr_ready = 1'b1; wr_done = 1'b0; wr_nack = 1'b0;
    wr_ready1 = 1'b1; wr_done1 = 1'b0; wr_nack1 = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_valid && wr_ready) begin
        a.rg = wr_reg; a.dt = wr_data; a.idx = int'(lut_index); a.cyc = cyc + 1;
        acc_q.push_back(a);
        if (int'(lut_index) == last_idx) attempts++;
        else attempts = 0;
        last_idx  = int'(lut_index);
        pend_nack = (int'(lut_index) == nack_idx) && (attempts < nack_n);
        done_cnt  = 3;
      end
      if (wr_valid1 && wr_ready1) begin
        a.rg = wr_reg1; a.dt = wr_data1; a.idx = int'(lut_index1); a.cyc = cyc + 1;
        pend_nack1 = (acc1_q.size() % 2) == 0;
        acc1_q.push_back(a);
        done1_cnt = 1;
      end
      @(posedge clk);
      #1;
      if (done_cnt > 0) begin
        done_cnt--;
        wr_done = (done_cnt == 0);
        wr_nack = (done_cnt == 0) ? pend_nack : 1'($urandom_range(0, 1));
      end else begin
        wr_done = 1'b0;
        wr_nack = 1'($urandom_range(0, 1));
      end
      if (done1_cnt > 0) begin
        done1_cnt--;
        wr_done1 = (done1_cnt == 0);
        wr_nack1 = (done1_cnt == 0) && pend_nack1;
      end else begin
        wr_done1 = 1'b0;
        wr_nack1 = 1'b0;
      end
      if (int'(lut_index) != bp_idx) stall_cnt = 0;
      if (wr_valid && (int'(lut_index) == bp_idx) && (stall_cnt < bp_len)) begin
        wr_ready = 1'b0;
        stall_cnt++;
      end else begin
        wr_ready = 1'b1;
      end
    end
  end

  // Expected write stream: each accept time follows from the phase lengths of the one before it
  task automatic build_exp(input int e0, output int fin_cyc, output int err_idx);
    acc_t e;
    int t, d, g, a;
    bit nk, stop;
    logic [15:0] w;
    exp_q.delete();
    err_idx = -1;
    fin_cyc = -1;
    t = e0 + P + 2;
    for (int idx = SIDX; idx <= EIDX && err_idx < 0; idx++) begin
      w = lut_mem[idx];
      a = 0;
      stop = 1'b0;
      while (!stop) begin
        if (idx == bp_idx && a == 0) t += bp_len;
        e.rg = w[15:8]; e.dt = w[7:0]; e.idx = idx; e.cyc = t;
        exp_q.push_back(e);
        d  = t + 3;
        g  = (w[15:8] == 8'h12 && w[7]) ? P : G;
        nk = (idx == nack_idx) && (a < nack_n);
        fin_cyc = d;
        if (!nk) begin
          t = d + g + 2;
          stop = 1'b1;
        end else if (a == MAXR) begin
          err_idx = idx;
          stop = 1'b1;
        end else begin
          t = d + g + 1;
          a++;
        end
      end
    end
  endtask

  function automatic int first_diff();
    int n = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (acc_q[i].rg !== exp_q[i].rg || acc_q[i].dt !== exp_q[i].dt ||
          acc_q[i].idx != exp_q[i].idx || acc_q[i].cyc != exp_q[i].cyc) return i;
    return (acc_q.size() == exp_q.size()) ? -1 : n;
  endfunction

  function automatic string diff_str(input int i);
    string s;
    s = $sformatf("entry %0d of got %0d/expected %0d", i, acc_q.size(), exp_q.size());
    if (i < acc_q.size()) s = {s, $sformatf(" got reg %h data %h idx %0d cyc %0d", acc_q[i].rg, acc_q[i].dt, acc_q[i].idx, acc_q[i].cyc)};
    if (i < exp_q.size()) s = {s, $sformatf(" expected reg %h data %h idx %0d cyc %0d", exp_q[i].rg, exp_q[i].dt, exp_q[i].idx, exp_q[i].cyc)};
    return s;
  endfunction

  task automatic do_start(output int e0);
    @(negedge clk);
    start = 1'b1;
    e0 = cyc + 1;
    acc_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int end_cyc, output int max_idx, output int stalls, output int unstable);
    end_cyc = -1; max_idx = 0; stalls = 0; unstable = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(lut_index) > max_idx) max_idx = int'(lut_index);
      if (wr_valid && !wr_ready) begin
        stalls++;
        if ({wr_reg, wr_data} !== lut_mem[bp_idx]) unstable++;
      end
      if (cfg_done || cfg_error) begin
        end_cyc = cyc;
        break;
      end
    end
  endtask

  int e0_main;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({wr_valid, busy, cfg_done, cfg_error} !== 4'b0000 || lut_index !== 8'd2 || fail_index !== 8'd0 ||
        wr_reg !== 8'd0 || wr_data !== 8'd0 || wr_dev !== 8'h42 || lut_index1 !== 8'd9) begin
      n_mis++;
      $display("FAIL reset_values: got valid %b busy %b done %b err %b idx %h fail %h reg %h data %h dev %h idx1 %h, expected 0 0 0 0 02 00 00 00 42 09",
               wr_valid, busy, cfg_done, cfg_error, lut_index, fail_index, wr_reg, wr_data, wr_dev, lut_index1);
    end
    acc_q.delete();
    rst = 1'b0;
    e0_main = cyc + 1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || wr_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_release: got busy %b valid %b, expected 1 0", busy, wr_valid);
    end
  endtask

  task automatic test_single_entry();
    while (cyc < e0_main + 12) @(negedge clk);
    n_cmp++;
    if (acc1_q.size() != 2) begin
      n_mis++;
      $display("FAIL single_count: got %0d accepts, expected 2", acc1_q.size());
    end else begin
      n_cmp++;
      if (acc1_q[0].cyc != e0_main + 5 || acc1_q[1].cyc != e0_main + 8 ||
          {acc1_q[1].rg, acc1_q[1].dt} !== lut_mem[9] || {acc1_q[0].rg, acc1_q[0].dt} !== lut_mem[9]) begin
        n_mis++;
        $display("FAIL single_stream: got cyc %0d/%0d word %h, expected cyc %0d/%0d word %h",
                 acc1_q[0].cyc, acc1_q[1].cyc, {acc1_q[1].rg, acc1_q[1].dt}, e0_main + 5, e0_main + 8, lut_mem[9]);
      end
    end
    n_cmp++;
    if ({cfg_done1, cfg_error1, busy1} !== 3'b100 || lut_index1 !== 8'd9 || wr_dev1 !== 8'h21) begin
      n_mis++;
      $display("FAIL single_status: got done %b err %b busy %b idx %h dev %h, expected 1 0 0 09 21",
               cfg_done1, cfg_error1, busy1, lut_index1, wr_dev1);
    end
  endtask

  task automatic test_nominal();
    int fin, err, endc, mx, st, us, fd;
    wait_end(4000, endc, mx, st, us);
    build_exp(e0_main, fin, err);
    fd = first_diff();
    n_cmp++;
    if (fd != -1) begin n_mis++; $display("FAIL nominal_stream: %s", diff_str(fd)); end
    n_cmp++;
    if (acc_q.size() != 166 || acc_q[0].rg !== 8'h12 || acc_q[0].dt !== 8'h14 ||
        acc_q[acc_q.size()-1].rg !== 8'h8C || acc_q[acc_q.size()-1].dt !== 8'h02) begin
      n_mis++;
      $display("FAIL nominal_ends: got %0d writes, expected 166 starting 12/14 ending 8C/02", acc_q.size());
    end
    n_cmp++;
    if (endc != fin || {cfg_done, cfg_error, busy} !== 3'b100 || mx > EIDX) begin
      n_mis++;
      $display("FAIL nominal_end: got end cyc %0d done %b err %b busy %b max idx %0d, expected cyc %0d 1 0 0 max<=%0d",
               endc, cfg_done, cfg_error, busy, mx, fin, EIDX);
    end
  endtask

  task automatic test_backpressure();
    int e0, fin, err, endc, mx, st, us, fd, n5;
    bp_idx = 5; bp_len = 7;
    do_start(e0);
    wait_end(4000, endc, mx, st, us);
    build_exp(e0, fin, err);
    fd = first_diff();
    n5 = 0;
    foreach (acc_q[i]) if (acc_q[i].idx == 5) n5++;
    n_cmp++;
    if (st != 7 || us != 0 || n5 != 1) begin
      n_mis++;
      $display("FAIL bp_stall: got %0d stall cycles %0d unstable %0d accepts, expected 7 0 1", st, us, n5);
    end
    n_cmp++;
    if (fd != -1 || endc != fin || cfg_done !== 1'b1) begin
      n_mis++;
      $display("FAIL bp_stream: end cyc %0d expected %0d done %b; %s", endc, fin, cfg_done, diff_str(fd < 0 ? 0 : fd));
    end
    bp_idx = 255; bp_len = 0;
  endtask

  task automatic test_retry();
    int e0, fin, err, endc, mx, st, us, fd, n40;
    nack_idx = 40; nack_n = 2;
    do_start(e0);
    wait_end(4000, endc, mx, st, us);
    build_exp(e0, fin, err);
    fd = first_diff();
    n40 = 0;
    foreach (acc_q[i]) if (acc_q[i].idx == 40 && {acc_q[i].rg, acc_q[i].dt} === lut_mem[40]) n40++;
    n_cmp++;
    if (n40 != 3) begin n_mis++; $display("FAIL retry_count: got %0d accepts of entry 40, expected 3", n40); end
    n_cmp++;
    if (fd != -1 || endc != fin || {cfg_done, cfg_error} !== 2'b10) begin
      n_mis++;
      $display("FAIL retry_stream: end cyc %0d expected %0d done %b err %b; %s", endc, fin, cfg_done, cfg_error, diff_str(fd < 0 ? 0 : fd));
    end
    nack_idx = 255; nack_n = 0;
  endtask

  task automatic test_error();
    int e0, fin, err, endc, mx, st, us, fd, nv;
    nack_idx = 10; nack_n = 1000;
    do_start(e0);
    wait_end(4000, endc, mx, st, us);
    build_exp(e0, fin, err);
    fd = first_diff();
    n_cmp++;
    if (fd != -1 || endc != fin) begin
      n_mis++;
      $display("FAIL error_stream: end cyc %0d expected %0d; %s", endc, fin, diff_str(fd < 0 ? 0 : fd));
    end
    n_cmp++;
    if ({cfg_error, cfg_done, busy} !== 3'b100 || int'(fail_index) != err || err != 10) begin
      n_mis++;
      $display("FAIL error_status: got err %b done %b busy %b fail %0d (model %0d), expected 1 0 0 10",
               cfg_error, cfg_done, busy, fail_index, err);
    end
    nv = 0;
    repeat (20) begin @(negedge clk); if (wr_valid) nv++; end
    n_cmp++;
    if (nv != 0) begin n_mis++; $display("FAIL error_quiet: got %0d valid cycles after error, expected 0", nv); end
    nack_idx = 255; nack_n = 0;
    do_start(e0);
    n_cmp++;
    if ({cfg_error, cfg_done, busy} !== 3'b001 || fail_index !== 8'd0) begin
      n_mis++;
      $display("FAIL error_restart: got err %b done %b busy %b fail %h, expected 0 0 1 00", cfg_error, cfg_done, busy, fail_index);
    end
    wait_end(4000, endc, mx, st, us);
    build_exp(e0, fin, err);
    fd = first_diff();
    n_cmp++;
    if (fd != -1 || endc != fin || {cfg_done, cfg_error} !== 2'b10) begin
      n_mis++;
      $display("FAIL error_rerun: end cyc %0d expected %0d done %b; %s", endc, fin, cfg_done, diff_str(fd < 0 ? 0 : fd));
    end
  endtask

  task automatic test_reset_in_wait();
    int e0, fin, err, endc, mx, st, us, fd, k, m, guard;
    do_start(e0);
    k = $urandom_range(10, 30);
    guard = 0;
    while (acc_q.size() < k && guard < 2000) begin @(negedge clk); guard++; end
    @(negedge clk);
    n_cmp++;
    if (acc_q.size() < k || wr_valid !== 1'b0 || busy !== 1'b1) begin
      n_mis++;
      $display("FAIL rstwait_setup: got %0d accepts valid %b busy %b, expected >=%0d 0 1", acc_q.size(), wr_valid, busy, k);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({wr_valid, busy} !== 2'b00 || lut_index !== 8'd2) begin
      n_mis++;
      $display("FAIL rstwait_abort: got valid %b busy %b idx %h, expected 0 0 02", wr_valid, busy, lut_index);
    end
    acc_q.delete();
    rst = 1'b0;
    e0 = cyc + 1;
    m = $urandom_range(20, 60);
    guard = 0;
    while (acc_q.size() < m && guard < 2000) begin @(negedge clk); guard++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(4000, endc, mx, st, us);
    build_exp(e0, fin, err);
    fd = first_diff();
    n_cmp++;
    if (fd != -1 || endc != fin || {cfg_done, cfg_error} !== 2'b10) begin
      n_mis++;
      $display("FAIL rstwait_rerun: end cyc %0d expected %0d done %b; %s", endc, fin, cfg_done, diff_str(fd < 0 ? 0 : fd));
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      if (w[15:8] == 8'h12) w[15:8] = 8'h13;
      lut_mem[i] = w[15:0];
    end
    lut_mem[2]   = 16'h1214;
    lut_mem[3]   = 16'h1280;
    lut_mem[167] = 16'h8C02;
    test_reset();
    test_single_entry();
    test_nominal();
    test_backpressure();
    test_retry();
    test_error();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
